// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, tick-sampled debounce,
// press edge detect and optional per-bit auto-repeat into one-cycle pulses.
//
// state     | meaning
// IDLE      | button released, no repeat timing in progress
// PRESSED   | debounced press seen, counting ticks toward first repeat
// REPEATING | first repeat issued, counting ticks between repeats
module button_conditioner #(
  parameter int WIDTH          = 3,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int REPEAT_DELAY   = 1000,
  parameter int REPEAT_PERIOD  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] held
);

  localparam int SW   = $clog2(SAMPLE_CNT_MAX);
  localparam int CW   = $clog2(PULSE_CNT_MAX + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [SW-1:0] TICK_VAL = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(PULSE_CNT_MAX);
  localparam logic [RW-1:0] DELAY_V  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] PERIOD_V = RW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEATING} rpt_state_t;

  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync;
  logic [SW-1:0]    sample_cnt;
  logic             tick;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] held_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fire;
  rpt_state_t       state      [WIDTH];
  rpt_state_t       state_next [WIDTH];
  logic [RW-1:0]    rep      [WIDTH];
  logic [RW-1:0]    rep_next [WIDTH];

  assign tick = (sample_cnt == TICK_VAL);
  assign rise = held & ~held_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a     <= '0;
      sync       <= '0;
      sample_cnt <= '0;
    end else begin
      sync_a     <= in;
      sync       <= sync_a;
      sample_cnt <= tick ? '0 : sample_cnt + SW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (tick) begin
        if (!sync[i])
          cnt_next[i] = '0;
        else if (cnt[i] != CNT_FULL)
          cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  // held is registered from cnt_next so it tracks cnt == full exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      held   <= '0;
      held_d <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i]  <= cnt_next[i];
        held[i] <= (cnt_next[i] == CNT_FULL);
      end
      held_d <= held;
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_next[i] = state[i];
      rep_next[i]   = rep[i];
      fire[i]       = 1'b0;
      if (!held[i]) begin
        state_next[i] = IDLE;
        rep_next[i]   = '0;
      end else begin
        case (state[i])
          IDLE: begin
            if (rise[i]) begin
              state_next[i] = PRESSED;
              rep_next[i]   = '0;
            end
          end
          PRESSED: begin
            if (tick && (REPEAT_DELAY != 0)) begin
              if (rep[i] + RW'(1) == DELAY_V) begin
                fire[i]       = 1'b1;
                rep_next[i]   = '0;
                state_next[i] = REPEATING;
              end else begin
                rep_next[i] = rep[i] + RW'(1);
              end
            end
          end
          REPEATING: begin
            if (tick) begin
              if (rep[i] + RW'(1) == PERIOD_V) begin
                fire[i]     = 1'b1;
                rep_next[i] = '0;
              end else begin
                rep_next[i] = rep[i] + RW'(1);
              end
            end
          end
          default: begin
            state_next[i] = IDLE;
            rep_next[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        rep[i]   <= '0;
      end
      out <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_next[i];
        rep[i]   <= rep_next[i];
      end
      out <= rise | fire;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a cycle-level
// reference built from the debounce/repeat timing rules (ticks, counts, spacing).
module tb_button_conditioner;
  localparam int W = 3;
  localparam int S = 4;
  localparam int P = 3;
  localparam int D = 4;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in;
  logic [W-1:0] out;
  logic [W-1:0] held;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference state: tick phase, 2-deep input delay, debounce count,
  // debounced level history and ticks counted since the press
  int mphase;
  bit ms1 [W];
  bit ms2 [W];
  bit mheld [W];
  bit mheld_d [W];
  bit mout [W];
  int mcnt [W];
  int mn [W];

  int pc, fp, fh, fl;

  always #5 clk = ~clk;

  button_conditioner #(
    .WIDTH(W), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(R)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .held(held)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mphase = 0;
    for (int i = 0; i < W; i++) begin
      ms1[i] = 0; ms2[i] = 0; mheld[i] = 0; mheld_d[i] = 0;
      mout[i] = 0; mcnt[i] = 0; mn[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit tk, old_h, older_h, fire;
    tk = (mphase == S - 1);
    mphase = (mphase + 1) % S;
    for (int i = 0; i < W; i++) begin
      old_h = mheld[i];
      older_h = mheld_d[i];
      fire = 0;
      if (!old_h) mn[i] = 0;
      else if (tk) begin
        mn[i]++;
        if (D > 0 && (mn[i] == D || (mn[i] > D && (mn[i] - D) % R == 0))) fire = 1;
      end
      mout[i] = (old_h && !older_h) || fire;
      mheld_d[i] = old_h;
      if (tk) mcnt[i] = ms2[i] ? ((mcnt[i] < P) ? mcnt[i] + 1 : P) : 0;
      mheld[i] = (mcnt[i] == P);
      ms2[i] = ms1[i];
      ms1[i] = in[i];
    end
  endtask

  task automatic step();
    logic [W-1:0] eo, eh;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    cyc++;
    #1;
    for (int i = 0; i < W; i++) begin
      eo[i] = mout[i];
      eh[i] = mheld[i];
    end
    check_val("out", out, eo);
    check_val("held", held, eh);
  endtask

  task automatic run(input int n, input int b, output int pulses, output int first_p,
                     output int first_h, output int first_l);
    pulses = 0; first_p = -1; first_h = -1; first_l = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (out[b] === 1'b1) begin
        pulses++;
        if (first_p < 0) first_p = k;
      end
      if (held[b] === 1'b1 && first_h < 0) first_h = k;
      if (held[b] === 1'b0 && first_l < 0) first_l = k;
    end
  endtask

  task automatic async_reset_check(input string tag, input int dly);
    #(dly);
    rst = 1'b1;
    #1;
    check_val({tag, "_out"}, out, '0);
    check_val({tag, "_held"}, held, '0);
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int f0, f1, o2, drop, tg, tot, exp_n;
    rst = 1'b1;
    in = '0;
    model_reset();
    #1;
    check_val("reset_out", out, '0);
    check_val("reset_held", held, '0);
    repeat (3) step();

    // clean press on bit 0, released on a tick that is not a repeat point
    #3 rst = 1'b0;
    in[0] = 1'b1;
    run(52, 0, pc, fp, fh, fl);
    check_val("press_latency_le16", (fh >= 1 && fh <= 16), 1);
    check_val("press_pulse_after_rise", fp, fh + 1);
    in[0] = 1'b0;
    run(10, 0, pc, fp, fh, fl);
    check_val("release_latency_le6", (fl >= 1 && fl <= 6), 1);
    check_val("release_no_pulse", pc, 0);

    // bounce on bit 1
    tot = 0;
    for (int s = 0; s < 20; s++) begin
      in[1] = ~in[1];
      run(3, 1, pc, fp, fh, fl);
      tot += pc;
    end
    check_val("bounce_no_pulse", tot, 0);
    in[1] = 1'b1;
    run(16, 1, pc, fp, fh, fl);
    check_val("bounce_stable_one_pulse", pc, 1);
    in[1] = 1'b0;
    run(10, 1, pc, fp, fh, fl);

    // auto-repeat on bit 2
    in[2] = 1'b1;
    fh = -1; drop = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (out[2] === 1'b1) q.push_back(k);
      if (held[2] === 1'b1 && fh < 0) fh = k;
      else if (fh > 0 && held[2] !== 1'b1) drop++;
    end
    exp_n = (fh > 0 && fh + D * S <= 100) ? 2 + (100 - (fh + D * S)) / (R * S) : 1;
    check_val("repeat_count", q.size(), exp_n);
    check_val("repeat_held_steady", drop, 0);
    if (q.size() >= 2) begin
      check_val("repeat_initial", q[0], fh + 1);
      check_val("repeat_first", q[1], fh + D * S);
      for (int j = 2; j < q.size(); j++) check_val("repeat_period", q[j] - q[j-1], R * S);
    end
    in[2] = 1'b0;
    run(10, 2, pc, fp, fh, fl);

    // simultaneous press
    in[0] = 1'b1;
    in[1] = 1'b1;
    f0 = -1; f1 = -1; o2 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out[0] === 1'b1 && f0 < 0) f0 = k;
      if (out[1] === 1'b1 && f1 < 0) f1 = k;
      if (out[2] !== 1'b0) o2++;
    end
    check_val("simul_seen", (f0 > 0), 1);
    check_val("simul_same_cycle", f1, f0);
    check_val("simul_bit2_quiet", o2, 0);
    in[1] = 1'b0;
    run(30, 0, pc, fp, fh, fl);

    // asynchronous reset while bit 0 is repeating
    async_reset_check("midrst", 3);
    repeat (3) step();
    #2 rst = 1'b0;
    run(20, 0, pc, fp, fh, fl);
    check_val("post_reset_held", fh, P * S);
    check_val("post_reset_pulse", fp, P * S + 1);

    // one low sample just before the count completes
    in[0] = 1'b0;
    run(10, 0, pc, fp, fh, fl);
    in[0] = 1'b1;
    for (int k = 0; k < 40 && mcnt[0] != 2; k++) step();
    in[0] = 1'b0;
    tg = -1;
    for (int k = 1; k <= 40 && tg < 0; k++) begin
      if (k == 5) in[0] = 1'b1;
      step();
      if (held[0] === 1'b1) tg = k;
    end
    check_val("glitch_restart", tg, S + P * S);
    in = '0;
    run(10, 0, pc, fp, fh, fl);

    // randomized levels, bounces and occasional resets
    for (int sg = 0; sg < 60; sg++) begin
      int dur;
      bit bouncy;
      in = W'($urandom_range(0, (1 << W) - 1));
      dur = $urandom_range(1, 40);
      bouncy = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < dur; c++) begin
        if (bouncy) in = in ^ W'($urandom_range(0, (1 << W) - 1));
        step();
      end
      if (sg == 20 || sg == 40) begin
        async_reset_check("rnd_rst", $urandom_range(1, 3));
        repeat (2) step();
        #2 rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
